// File: rtl/riscv_branch_predictor.sv
// Direct-mapped branch predictor: one table entry per index holding a valid
// bit, a tag, a 2-bit saturating direction counter and a branch target.
// Lookups return a registered prediction one cycle later; updates arrive
// from the execute stage and train or allocate entries. The table is built
// from flops so that an asynchronous reset can clear it at once.
module riscv_branch_predictor #(
  parameter int WIDTH = 32,
  parameter int IDX_W = 4,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             lookup_valid,
  input  logic [WIDTH-1:0] lookup_pc,
  output logic             pred_valid,
  output logic             pred_hit,
  output logic             pred_taken,
  output logic [WIDTH-1:0] pred_target,
  input  logic             upd_valid,
  input  logic [WIDTH-1:0] upd_pc,
  input  logic             upd_taken,
  input  logic [WIDTH-1:0] upd_target,
  input  logic             upd_pred_taken,
  input  logic             flush,
  output logic             mispredict,
  output logic [15:0]      mispred_cnt
);

  localparam int ENTRIES = 1 << IDX_W;

  // Index and tag fields; bits [1:0] of the PC never take part.
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;

  assign lk_idx = lookup_pc[IDX_W+1:2];
  assign lk_tag = lookup_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign up_idx = upd_pc[IDX_W+1:2];
  assign up_tag = upd_pc[IDX_W+TAG_W+1:IDX_W+2];

  // PC bits outside the index/tag fields are intentionally ignored.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{lookup_pc, upd_pc};

  // Flattened view of every entry, used by the lookup and update read ports.
  logic [ENTRIES-1:0] ent_valid;
  logic [TAG_W-1:0]   ent_tag [ENTRIES];
  logic [1:0]         ent_ctr [ENTRIES];
  logic [WIDTH-1:0]   ent_tgt [ENTRIES];

  // Update-side tag check against the current (pre-write) contents.
  logic upd_hit;
  assign upd_hit = ent_valid[up_idx] && (ent_tag[up_idx] == up_tag);

  // Lookup-side tag check, also against pre-write contents (read-before-write).
  logic lk_hit;
  assign lk_hit = ent_valid[lk_idx] && (ent_tag[lk_idx] == lk_tag);

  genvar gi;
  generate
    for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
      logic             valid_q, valid_d;
      logic [TAG_W-1:0] tag_q, tag_d;
      logic [1:0]       ctr_q, ctr_d;
      logic [WIDTH-1:0] tgt_q, tgt_d;
      logic             upd_sel;

      assign upd_sel = upd_valid && (up_idx == IDX_W'(gi));

      // Entry next state: flush wins, then hit training, then taken-miss allocation.
      always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        ctr_d   = ctr_q;
        tgt_d   = tgt_q;
        if (flush) begin
          valid_d = 1'b0;
        end else if (upd_sel) begin
          if (upd_hit) begin
            if (upd_taken) begin
              if (ctr_q != 2'b11) ctr_d = ctr_q + 2'd1;
              tgt_d = upd_target;
            end else begin
              if (ctr_q != 2'b00) ctr_d = ctr_q - 2'd1;
            end
          end else if (upd_taken) begin
            valid_d = 1'b1;
            tag_d   = up_tag;
            ctr_d   = 2'b10;
            tgt_d   = upd_target;
          end
        end
      end

      // Entry storage; reset leaves entries invalid and weakly not-taken.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          valid_q <= 1'b0;
          tag_q   <= '0;
          ctr_q   <= 2'b01;
          tgt_q   <= '0;
        end else begin
          valid_q <= valid_d;
          tag_q   <= tag_d;
          ctr_q   <= ctr_d;
          tgt_q   <= tgt_d;
        end
      end

      assign ent_valid[gi] = valid_q;
      assign ent_tag[gi]   = tag_q;
      assign ent_ctr[gi]   = ctr_q;
      assign ent_tgt[gi]   = tgt_q;
    end
  endgenerate

  // Prediction registers; they hold their last value when no lookup is issued.
  logic             pred_valid_q;
  logic             pred_hit_q, pred_hit_d;
  logic             pred_taken_q, pred_taken_d;
  logic [WIDTH-1:0] pred_target_q, pred_target_d;

  // Prediction next state from the addressed entry.
  always_comb begin
    pred_hit_d    = pred_hit_q;
    pred_taken_d  = pred_taken_q;
    pred_target_d = pred_target_q;
    if (lookup_valid) begin
      pred_hit_d    = lk_hit;
      pred_taken_d  = lk_hit && ent_ctr[lk_idx][1];
      pred_target_d = lk_hit ? ent_tgt[lk_idx] : '0;
    end
  end

  // Prediction output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_valid_q  <= 1'b0;
      pred_hit_q    <= 1'b0;
      pred_taken_q  <= 1'b0;
      pred_target_q <= '0;
    end else begin
      pred_valid_q  <= lookup_valid;
      pred_hit_q    <= pred_hit_d;
      pred_taken_q  <= pred_taken_d;
      pred_target_q <= pred_target_d;
    end
  end

  // Mispredict detection is independent of flush so dropped updates still count.
  logic        mispredict_q, mispredict_d;
  logic [15:0] cnt_q, cnt_d;

  // Mispredict pulse and saturating counter next state.
  always_comb begin
    mispredict_d = upd_valid && (upd_taken ^ upd_pred_taken);
    cnt_d        = cnt_q;
    if (mispredict_q && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
  end

  // Mispredict registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mispredict_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      mispredict_q <= mispredict_d;
      cnt_q        <= cnt_d;
    end
  end

  assign pred_valid  = pred_valid_q;
  assign pred_hit    = pred_hit_q;
  assign pred_taken  = pred_taken_q;
  assign pred_target = pred_target_q;
  assign mispredict  = mispredict_q;
  assign mispred_cnt = cnt_q;

endmodule

// File: doc/riscv_branch_predictor.md
RISCV_BRANCH_PREDICTOR -- requirements
Module: riscv_branch_predictor

Interface
REQ-001 Parameter WIDTH, default 32, PC and target width in bits.
REQ-002 Parameter IDX_W, default 4, index bits; the table has 2**IDX_W entries.
REQ-003 Parameter TAG_W, default 8, stored tag bits per entry.
REQ-004 clk  input  1  Single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  Reset, asynchronous and active-low.
REQ-006 lookup_valid  input  1  Fetch-stage lookup request this cycle.
REQ-007 lookup_pc  input  WIDTH  PC of the instruction being fetched.
REQ-008 pred_valid  output  1  Prediction for the lookup of the previous cycle is valid.
REQ-009 pred_hit  output  1  Tag hit on a valid entry.
REQ-010 pred_taken  output  1  Predicted direction.
REQ-011 pred_target  output  WIDTH  Predicted target.
REQ-012 upd_valid  input  1  Resolved branch from the execute-stage branch comparator.
REQ-013 upd_pc  input  WIDTH  PC of the resolved branch.
REQ-014 upd_taken  input  1  Resolved direction (the comparator branch_out).
REQ-015 upd_target  input  WIDTH  Resolved target address.
REQ-016 upd_pred_taken  input  1  Direction that was predicted for this branch.
REQ-017 flush  input  1  Synchronous invalidate of all entries.
REQ-018 mispredict  output  1  One-cycle pulse on a direction mispredict.
REQ-019 mispred_cnt  output  16  Saturating count of mispredicts.

Function
REQ-020 Each entry SHALL hold a valid bit, a TAG_W tag, a 2-bit saturating counter and a WIDTH target.
REQ-021 index = pc[IDX_W+1:2] and tag = pc[IDX_W+TAG_W+1:IDX_W+2] for both lookup and update; pc[1:0] is ignored.
REQ-022 Lookup latency SHALL be exactly 1 cycle: pred_valid = lookup_valid registered.
REQ-023 The pred_* outputs SHALL be registered.
REQ-024 On a valid lookup:
  - pred_hit = entry valid AND tag match.
  - pred_taken = pred_hit AND counter[1].
  - pred_target = entry target on a hit, else 0.
REQ-025 When lookup_valid=0, pred_valid=0 on the next cycle and pred_hit/pred_taken/pred_target SHALL hold their previous values.
REQ-026 Update on a hit: counter increments if upd_taken, else decrements, saturating at 2'b11 and 2'b00. The target is rewritten only when upd_taken=1.
REQ-027 Update on a miss with upd_taken=1: allocate (overwrite) the entry with valid=1, the new tag, counter=2'b10 and target=upd_target.
REQ-028 Update on a miss with upd_taken=0: no table change.
REQ-029 Lookup and update to the same index in the same cycle: the lookup SHALL return the pre-update entry (read-before-write).
REQ-030 mispredict SHALL be upd_valid AND (upd_taken XOR upd_pred_taken), registered, so it asserts 1 cycle after the update.
REQ-031 mispred_cnt SHALL increment when mispredict is asserted and saturate at 16'hFFFF.
REQ-032 flush SHALL clear all valid bits at the next edge; counters and targets are retained.
REQ-033 Flush priority:
  - flush has priority over an upd_valid in the same cycle; that update is dropped.
  - mispredict and mispred_cnt still respond to that update.
  - A lookup in the flush cycle reads the pre-flush state.
REQ-034 flush SHALL NOT clear mispred_cnt.

Reset
REQ-035 While rst_n=0: all valid bits=0, all counters=2'b01, all targets=0.
REQ-036 While rst_n=0: pred_valid, pred_hit, pred_taken, pred_target, mispredict and mispred_cnt SHALL all be 0.
REQ-037 Reset asserted mid-operation SHALL clear state immediately, without waiting for a clock edge.
REQ-038 After deassertion, the first lookup SHALL miss.

Verification
REQ-039 Post-reset lookup, lookup_pc=0x100 -> next cycle pred_valid=1, pred_hit=0, pred_taken=0, pred_target=0.
REQ-040 Update 0x100 taken, target 0x200, then lookup 0x100 -> pred_hit=1, pred_taken=1, pred_target=0x200.
REQ-041 Apply three not-taken updates to 0x100 -> counter 10→01→00→00; lookup gives pred_hit=1, pred_taken=0. Then two taken updates -> pred_taken=1.
REQ-042 Aliasing: with 0x100 allocated, lookup 0x140 (same index, different tag) -> pred_hit=0. A taken update at 0x140 then evicts it, so lookup 0x100 -> pred_hit=0.
REQ-043 Same-cycle lookup and taken allocate at 0x100 -> that lookup misses and the following lookup hits. flush together with upd_valid -> no allocation, mispredict still pulses.
REQ-044 Force mispredicts with upd_taken≠upd_pred_taken over 65,537 updates -> mispred_cnt=16'hFFFF and holds. An rst_n pulse mid-stream returns all outputs to 0 asynchronously.
